// File: rtl/egress_collector_pkg.sv
// Shared definitions for the egress collector: FSM encoding, destination tags
// and default widths.
package egress_collector_pkg;
  localparam int DATA_SIZE_DEF = 6;
  localparam int CNT_W_DEF     = 16;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/egress_collector_if.sv
// Bundle of the D-FIFO pop side, the tagged output stream and status/counters.
interface egress_collector_if #(
  parameter int DATA_SIZE = egress_collector_pkg::DATA_SIZE_DEF,
  parameter int CNT_W     = egress_collector_pkg::CNT_W_DEF
);
  logic                 en;
  logic                 empty_in_0;
  logic                 empty_in_1;
  logic [DATA_SIZE-1:0] data_in_0;
  logic [DATA_SIZE-1:0] data_in_1;
  logic                 pop_d0;
  logic                 pop_d1;
  logic [DATA_SIZE-1:0] data_o;
  logic                 dest_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 busy_o;
  logic [CNT_W-1:0]     cnt_d0_o;
  logic [CNT_W-1:0]     cnt_d1_o;

  modport slave (
    input  en, empty_in_0, empty_in_1, data_in_0, data_in_1, ready_i,
    output pop_d0, pop_d1, data_o, dest_o, valid_o, busy_o, cnt_d0_o, cnt_d1_o
  );

  modport master (
    output en, empty_in_0, empty_in_1, data_in_0, data_in_1, ready_i,
    input  pop_d0, pop_d1, data_o, dest_o, valid_o, busy_o, cnt_d0_o, cnt_d1_o
  );
endinterface

// File: rtl/egress_skid_fifo.sv
// Two-entry FIFO of {dest, data}; a push into a full FIFO is taken when the
// head is popped in the same cycle.
module egress_skid_fifo
  import egress_collector_pkg::*;
#(
  parameter int W = DATA_SIZE_DEF + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [1:0][W-1:0] mem;
  logic              wp, rp;
  logic [1:0]        cnt;
  logic              do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
endmodule

// File: rtl/egress_collector.sv
// Round-robin popper for the two destination FIFOs feeding one tagged stream.
// EGRESS_STATS_EN builds the per-destination accepted-word counters.
module egress_collector
  import egress_collector_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  egress_collector_if.slave bus
);
  localparam int EW = DATA_SIZE + 1;

  state_e          state, state_nxt;
  logic [1:0]      empty_in, elig, grant;
  logic [1:0][1:0] lock;
  logic            rr;
  logic            flight_vld, flight_dest;
  logic            credit_ok, accept;
  logic            fifo_full, fifo_empty;
  logic [1:0]      occ, pending;
  logic [EW-1:0]   push_word, head;

  assign empty_in = {bus.empty_in_1, bus.empty_in_0};
  assign occ      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign accept   = !fifo_empty && bus.ready_i;
  // A slot freed by this cycle's accept can be re-promised to a new pop.
  assign pending   = occ + {1'b0, flight_vld} - {1'b0, accept};
  assign credit_ok = (pending < 2'd2);

  // Two-cycle lockout covers the lag of the registered empty flag.
  for (genvar ch = 0; ch < 2; ch++) begin : g_elig
    assign elig[ch] = (state == RUN) && !empty_in[ch] && (lock[ch] == 2'b00) && credit_ok;
  end

  always_comb begin
    grant = 2'b00;
    if (elig == 2'b11) grant = (rr == DEST_D1) ? 2'b10 : 2'b01;
    else               grant = elig;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr          <= DEST_D0;
      lock        <= '0;
      flight_vld  <= 1'b0;
      flight_dest <= DEST_D0;
    end else begin
      state <= state_nxt;
      for (int c = 0; c < 2; c++) lock[c] <= {lock[c][0], grant[c]};
      if (grant[0])      rr <= DEST_D1;
      else if (grant[1]) rr <= DEST_D0;
      flight_vld  <= |grant;
      flight_dest <= grant[1];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = RUN;
      RUN:     if (!bus.en) state_nxt = DRAIN;
      DRAIN: begin
        if (bus.en)                          state_nxt = RUN;
        else if (!flight_vld && fifo_empty)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data of last cycle's pop is valid now; tag it with its source.
  assign push_word = {flight_dest, (flight_dest == DEST_D1) ? bus.data_in_1 : bus.data_in_0};

  egress_skid_fifo #(.W(EW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (flight_vld),
    .din   (push_word),
    .pop   (accept),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.pop_d0  = grant[0];
  assign bus.pop_d1  = grant[1];
  assign bus.valid_o = !fifo_empty;
  assign bus.dest_o  = head[EW-1];
  assign bus.data_o  = head[DATA_SIZE-1:0];
  assign bus.busy_o  = (state != IDLE) || flight_vld || !fifo_empty;

`ifdef EGRESS_STATS_EN
  logic [CNT_W-1:0] cnt_d0, cnt_d1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_d0 <= '0;
      cnt_d1 <= '0;
    end else if (accept) begin
      if (bus.dest_o == DEST_D1) cnt_d1 <= cnt_d1 + 1'b1;
      else                       cnt_d0 <= cnt_d0 + 1'b1;
    end
  end

  assign bus.cnt_d0_o = cnt_d0;
  assign bus.cnt_d1_o = cnt_d1;
`else
  assign bus.cnt_d0_o = {CNT_W{1'b0}};
  assign bus.cnt_d1_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_egress_collector.sv
// Bench for egress_collector: models the two D FIFOs and predicts the output
// stream, pop eligibility and counters from the collection rules.
module tb_egress_collector;
  import egress_collector_pkg::*;
  localparam int DW = 6;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  egress_collector_if #(.DATA_SIZE(DW), .CNT_W(CW)) bus();

  egress_collector #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          dest;
    logic [DW-1:0] data;
    int            cyc;
  } ent_t;

  ent_t          exp_q[$];
  logic [DW-1:0] q0[$], q1[$];
  logic [DW-1:0] acc_data[$];
  logic          acc_dest[$];
  logic          pop_dest[$];
  int            pop0_cyc[$];
  int            vectors = 0, miscompares = 0, cyc = 0;
  int            n_acc0 = 0, n_acc1 = 0;
  logic          emp0 = 1'b1, emp1 = 1'b1;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          pop_s0 = 1'b0, pop_s1 = 1'b0;
  logic [1:0]    h0 = 2'b00, h1 = 2'b00;
  logic          run_m = 1'b0;

  assign bus.empty_in_0 = emp0;
  assign bus.empty_in_1 = emp1;
  assign bus.data_in_0  = din0;
  assign bus.data_in_1  = din1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(int n);
`ifdef EGRESS_STATS_EN
    logic [CW-1:0] w;
    w = n[CW-1:0];
    return 32'(w);
`else
    return (n == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  // Upstream FIFOs: empty flag lags queue state by a cycle, read data the cycle after pop.
  always @(posedge clk) begin
    emp0 <= (q0.size() == 0);
    emp1 <= (q1.size() == 0);
    if (pop_s0 && !reset && q0.size() > 0) begin din0 <= q0[0]; void'(q0.pop_front()); end
    if (pop_s1 && !reset && q1.size() > 0) begin din1 <= q1[0]; void'(q1.pop_front()); end
  end

  // Collector is running in a cycle iff en was seen at the preceding edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      run_m <= 1'b0;
      h0    <= 2'b00;
      h1    <= 2'b00;
    end else begin
      run_m <= bus.en;
      h0    <= {h0[0], pop_s0};
      h1    <= {h1[0], pop_s1};
    end
  end

  always @(negedge clk) begin
    int   outst, acc;
    logic ev, p0, p1, e0, e1, want;
    cyc++;
    if (reset) begin
      pop_s0 = 1'b0;
      pop_s1 = 1'b0;
      exp_q.delete();
      n_acc0 = 0;
      n_acc1 = 0;
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_pops", {bus.pop_d1, bus.pop_d0}, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_data", bus.data_o, 0);
      chk("rst_cnt", {bus.cnt_d1_o, bus.cnt_d0_o}, 0);
    end else begin
      p0    = bus.pop_d0;
      p1    = bus.pop_d1;
      outst = exp_q.size();
      ev    = (outst > 0) && (exp_q[0].cyc <= cyc - 2);
      acc   = (ev && bus.ready_i) ? 1 : 0;
      chk("valid", bus.valid_o, ev);
      if (ev) begin
        chk("data", bus.data_o, exp_q[0].data);
        chk("dest", bus.dest_o, exp_q[0].dest);
      end
      chk("one_pop", p0 & p1, 0);
      e0   = !emp0 && (h0 == 2'b00);
      e1   = !emp1 && (h1 == 2'b00);
      want = run_m && (outst - acc < 2) && (e0 || e1);
      chk("pop_any", p0 | p1, want);
      if (p0) chk("pop0_nonempty", q0.size() > 0, 1);
      if (p1) chk("pop1_nonempty", q1.size() > 0, 1);
      chk("cnt_d0", bus.cnt_d0_o, exp_cnt(n_acc0));
      chk("cnt_d1", bus.cnt_d1_o, exp_cnt(n_acc1));
      if (run_m || outst > 0) chk("busy", bus.busy_o, 1);
      if (acc != 0) begin
        acc_data.push_back(exp_q[0].data);
        acc_dest.push_back(exp_q[0].dest);
        if (exp_q[0].dest) n_acc1++; else n_acc0++;
        void'(exp_q.pop_front());
      end
      if (p0 && q0.size() > 0) begin
        exp_q.push_back('{1'b0, q0[0], cyc});
        pop_dest.push_back(1'b0);
        pop0_cyc.push_back(cyc);
      end
      if (p1 && q1.size() > 0) begin
        exp_q.push_back('{1'b1, q1[0], cyc});
        pop_dest.push_back(1'b1);
      end
      pop_s0 = p0;
      pop_s1 = p1;
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete(); q1.delete();
    acc_data.delete(); acc_dest.delete(); pop_dest.delete(); pop0_cyc.delete();
    step(3);
    reset = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int k = 0;
    while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0) && k < 300) begin
      step(1);
      k++;
    end
    step(2);
    chk(name, k < 300, 1);
  endtask

  initial begin
    logic [DW-1:0] e2[3]   = '{6'h05, 6'h06, 6'h07};
    logic [DW-1:0] e3[8]   = '{6'h10, 6'h20, 6'h11, 6'h21, 6'h12, 6'h22, 6'h13, 6'h23};
    logic [DW-1:0] e4[6]   = '{6'h30, 6'h38, 6'h31, 6'h39, 6'h32, 6'h3A};
    int            k;

    // 1: reset with en=1 and both FIFOs non-empty
    bus.en = 1'b1;
    bus.ready_i = 1'b1;
    q0 = '{6'h11, 6'h12};
    q1 = '{6'h21, 6'h22};
    step(3);
    chk("t1_rst_pop", {bus.pop_d1, bus.pop_d0}, 2'b00);
    chk("t1_rst_valid", bus.valid_o, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t1_first_pop", {bus.pop_d1, bus.pop_d0}, 2'b01);
    wait_drain("t1_drain");
    chk("t1_words", acc_data.size(), 4);

    // 2: D0 only, three words
    do_reset();
    q0 = '{6'h05, 6'h06, 6'h07};
    wait_drain("t2_drain");
    chk("t2_npops", pop0_cyc.size(), 3);
    if (pop0_cyc.size() == 3) begin
      chk("t2_gap1", pop0_cyc[1] - pop0_cyc[0], 3);
      chk("t2_gap2", pop0_cyc[2] - pop0_cyc[1], 3);
    end
    chk("t2_nwords", acc_data.size(), 3);
    for (int i = 0; i < 3 && i < acc_data.size(); i++) begin
      chk("t2_word", acc_data[i], e2[i]);
      chk("t2_dest", acc_dest[i], 0);
    end
`ifdef EGRESS_STATS_EN
    chk("t2_cnt_d0", bus.cnt_d0_o, 3);
`else
    chk("t2_cnt_d0", bus.cnt_d0_o, 0);
`endif
    chk("t2_cnt_d1", bus.cnt_d1_o, 0);

    // 3: both non-empty, alternating service
    do_reset();
    q0 = '{6'h10, 6'h11, 6'h12, 6'h13};
    q1 = '{6'h20, 6'h21, 6'h22, 6'h23};
    wait_drain("t3_drain");
    chk("t3_npops", pop_dest.size(), 8);
    for (int i = 0; i < 8 && i < pop_dest.size(); i++) chk("t3_pop_dest", pop_dest[i], i % 2);
    chk("t3_nwords", acc_data.size(), 8);
    for (int i = 0; i < 8 && i < acc_data.size(); i++) begin
      chk("t3_word", acc_data[i], e3[i]);
      chk("t3_dest", acc_dest[i], i % 2);
    end

    // 4: back-pressure stops popping at two outstanding words
    do_reset();
    bus.ready_i = 1'b0;
    q0 = '{6'h30, 6'h31, 6'h32};
    q1 = '{6'h38, 6'h39, 6'h3A};
    step(12);
    chk("t4_npops", pop_dest.size(), 2);
    chk("t4_valid", bus.valid_o, 1);
    chk("t4_head", bus.data_o, 6'h30);
    step(3);
    chk("t4_head_hold", bus.data_o, 6'h30);
    chk("t4_npops_hold", pop_dest.size(), 2);
    bus.ready_i = 1'b1;
    wait_drain("t4_drain");
    chk("t4_nwords", acc_data.size(), 6);
    for (int i = 0; i < 6 && i < acc_data.size(); i++) chk("t4_word", acc_data[i], e4[i]);

    // 5: en falls one cycle after a pop
    do_reset();
    q0 = '{6'h2A};
    k = 0;
    while (pop0_cyc.size() == 0 && k < 20) begin step(1); k++; end
    chk("t5_pop_seen", k < 20, 1);
    bus.en = 1'b0;
    q0.push_back(6'h2B);
    q0.push_back(6'h2C);
    step(15);
    chk("t5_nwords", acc_data.size(), 1);
    if (acc_data.size() > 0) chk("t5_word", acc_data[0], 6'h2A);
    chk("t5_busy", bus.busy_o, 0);
    chk("t5_no_more_pops", pop0_cyc.size(), 1);
    bus.en = 1'b1;

    // 6: reset with two words buffered
    do_reset();
    q0 = '{6'h01, 6'h02, 6'h03, 6'h04};
    q1 = '{6'h09, 6'h0A, 6'h0B, 6'h0C};
    step(6);
    bus.ready_i = 1'b0;
    step(8);
    chk("t6_valid", bus.valid_o, 1);
    chk("t6_outstanding", exp_q.size(), 2);
`ifdef EGRESS_STATS_EN
    chk("t6_cnt_nz", (bus.cnt_d0_o != 0), 1);
`else
    chk("t6_cnt_zero", bus.cnt_d0_o, 0);
`endif
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", bus.valid_o, 0);
    chk("t6_async_cnt", {bus.cnt_d1_o, bus.cnt_d0_o}, 0);
    chk("t6_async_busy", bus.busy_o, 0);
    step(2);
    reset = 1'b0;
    bus.ready_i = 1'b1;
    wait_drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
